// File: rtl/ad9231_trig_capture.sv
// ---------------------------------------------------------------------------
// ad9231_trig_capture
//
// Purpose:
//   Sits behind the AD9231 dual-channel reader in the clk_200m domain. Channel
//   A/B samples go into a DEPTH-entry circular buffer. A rising level crossing
//   on the selected channel freezes a window of PRE_TRIG samples before the
//   trigger sample, the trigger sample itself, and the samples after it, for
//   DEPTH samples in all. The readout logic then drains the window, oldest
//   sample first, through a read-request / read-valid handshake.
//
// Parameters:
//   AW        buffer address width, DEPTH = 2**AW samples
//   PRE_TRIG  samples kept before the trigger sample (1 .. DEPTH-1)
//   DW        per-channel sample width (offset binary)
//
// Ports:
//   clk_200m      in   system clock
//   rst           in   asynchronous, active-high reset
//   sample_stb    in   one-cycle strobe, cha_dat/chb_dat are new this cycle
//   cha_dat       in   channel A sample
//   chb_dat       in   channel B sample
//   arm           in   one-cycle pulse, starts a capture (IDLE only)
//   trig_src      in   trigger channel, 0 = A, 1 = B
//   trig_level    in   trigger threshold, unsigned compare
//   force_trig    in   software trigger (only with AD9231_SOFT_TRIG_EN)
//   busy          out  capture in progress (PRE, WAIT, POST)
//   capture_done  out  window frozen and ready for readout (DONE)
//   trig_addr     out  buffer address of the trigger sample
//   rd_en         in   read request, honoured only in DONE
//   rd_dat        out  {chb, cha} sample, holds when rd_valid = 0
//   rd_valid      out  qualifies rd_dat, one cycle after an accepted rd_en
//
// Build option:
//   AD9231_SOFT_TRIG_EN  adds force_trig; when high with a strobe in WAIT it
//                        triggers like a level crossing.
// ---------------------------------------------------------------------------
module ad9231_trig_capture #(
    parameter int AW       = 10,
    parameter int PRE_TRIG = 128,
    parameter int DW       = 12
) (
    input  logic            clk_200m,
    input  logic            rst,
    input  logic            sample_stb,
    input  logic [DW-1:0]   cha_dat,
    input  logic [DW-1:0]   chb_dat,
    input  logic            arm,
    input  logic            trig_src,
    input  logic [DW-1:0]   trig_level,
`ifdef AD9231_SOFT_TRIG_EN
    input  logic            force_trig,
`endif
    output logic            busy,
    output logic            capture_done,
    output logic [AW-1:0]   trig_addr,
    input  logic            rd_en,
    output logic [2*DW-1:0] rd_dat,
    output logic            rd_valid
);

    localparam int DEPTH = 1 << AW;

    localparam logic [AW-1:0] ONE_A     = AW'(1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
    // Samples still to be written after the trigger sample.
    localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW-1:0] RD_LAST   = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_pre_cnt;
    logic [AW-1:0]     r_post_cnt;
    logic [AW-1:0]     r_rd_cnt;
    logic [DW-1:0]     r_prev_sel;
    logic              r_prev_valid;
    logic [AW-1:0]     r_trig_addr;
    logic              r_busy;
    logic              r_capture_done;
    logic [2*DW-1:0]   r_rd_dat;
    logic              r_rd_valid;
    logic [2*DW-1:0]   r_mem [DEPTH];

    logic              w_wr_en;
    logic [DW-1:0]     w_sel;
    logic              w_level_hit;
    logic              w_force;
    logic              w_trig;
    logic              w_rd_acc;

    // Every strobe in an active capture state lands in the buffer.
    assign w_wr_en = sample_stb &&
                     ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST));

    assign w_sel       = trig_src ? chb_dat : cha_dat;
    assign w_level_hit = r_prev_valid && (r_prev_sel < trig_level) && (w_sel >= trig_level);

`ifdef AD9231_SOFT_TRIG_EN
    assign w_force = force_trig;
`else
    assign w_force = 1'b0;
`endif

    // Only meaningful in WAIT; the FSM qualifies it with the state.
    assign w_trig   = sample_stb && (w_level_hit || w_force);
    assign w_rd_acc = rd_en && (r_state == S_DONE);

    // NOTE: the sample buffer has no reset; its contents are don't-care until
    // written, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk_200m) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {chb_dat, cha_dat};
        end
    end

    // Registered read port: data and valid appear one cycle after the request.
    always_ff @(posedge clk_200m or posedge rst) begin
        if (rst) begin
            r_rd_dat   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_dat <= r_mem[r_rd_ptr];
            end
        end
    end

    // Capture controller. Outputs busy/capture_done are registered alongside
    // every state change so they always agree with r_state.
    always_ff @(posedge clk_200m or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_pre_cnt      <= '0;
            r_post_cnt     <= '0;
            r_rd_cnt       <= '0;
            r_prev_sel     <= '0;
            r_prev_valid   <= 1'b0;
            r_trig_addr    <= '0;
            r_busy         <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ONE_A;
            end

            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state      <= S_PRE;
                        r_pre_cnt    <= '0;
                        r_prev_valid <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end

                S_PRE: begin
                    if (sample_stb) begin
                        r_prev_sel   <= w_sel;
                        r_prev_valid <= 1'b1;
                        r_pre_cnt    <= r_pre_cnt + ONE_A;
                        // The strobe completing the pre-trigger fill is not
                        // evaluated as a trigger; WAIT starts with the next one.
                        if (r_pre_cnt == PRE_LAST) begin
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (sample_stb) begin
                        r_prev_sel   <= w_sel;
                        r_prev_valid <= 1'b1;
                        if (w_trig) begin
                            r_trig_addr <= r_wr_ptr;
                            r_post_cnt  <= POST_LOAD;
                            if (POST_LOAD == '0) begin
                                // Window is already complete with the trigger sample.
                                r_state        <= S_DONE;
                                r_busy         <= 1'b0;
                                r_capture_done <= 1'b1;
                                r_rd_ptr       <= r_wr_ptr - PRE_OFS;
                                r_rd_cnt       <= '0;
                            end else begin
                                r_state <= S_POST;
                            end
                        end
                    end
                end

                S_POST: begin
                    if (sample_stb) begin
                        r_post_cnt <= r_post_cnt - ONE_A;
                        // This strobe writes the last sample of the window.
                        if (r_post_cnt == ONE_A) begin
                            r_state        <= S_DONE;
                            r_busy         <= 1'b0;
                            r_capture_done <= 1'b1;
                            r_rd_ptr       <= r_trig_addr - PRE_OFS;
                            r_rd_cnt       <= '0;
                        end
                    end
                end

                S_DONE: begin
                    if (w_rd_acc) begin
                        r_rd_ptr <= r_rd_ptr + ONE_A;
                        r_rd_cnt <= r_rd_cnt + ONE_A;
                        if (r_rd_cnt == RD_LAST) begin
                            r_state        <= S_IDLE;
                            r_capture_done <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                    r_capture_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign capture_done = r_capture_done;
    assign trig_addr    = r_trig_addr;
    assign rd_dat       = r_rd_dat;
    assign rd_valid     = r_rd_valid;

endmodule
